// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler slice.
// Contents:
//   - default parameter constants
//   - emergency FSM state enum
//   - helper that sizes a counter for a given maximum value
package traffic_pkg;

  localparam int unsigned DefTickDiv  = 100;
  localparam int unsigned DefDebTicks = 3;
  localparam int unsigned DefEmgHold  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPreempt = 2'd1,
    StHold    = 2'd2
  } emg_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the scheduler and its environment.
// Raw inputs:
//   - sa_raw, sb_raw, emg_raw: asynchronous sensor and emergency inputs
//   - ga, gb: controller green feedback
// Outputs:
//   - tick: phase-step enable
//   - Sa, Sb: latched road requests
//   - emergency: stretched preemption request
// Modports:
//   - slave: the scheduler
//   - master: whoever drives the raw inputs and consumes the requests
interface traffic_phase_scheduler_if;
  logic sa_raw;
  logic sb_raw;
  logic emg_raw;
  logic ga;
  logic gb;
  logic tick;
  logic Sa;
  logic Sb;
  logic emergency;

  modport slave (
    input  sa_raw, sb_raw, emg_raw, ga, gb,
    output tick, Sa, Sb, emergency
  );

  modport master (
    output sa_raw, sb_raw, emg_raw, ga, gb,
    input  tick, Sa, Sb, emergency
  );
endinterface

// File: rtl/sensor_debounce.sv
// One road sensor path: 2-FF synchronizer, tick-sampled debounce counter and
// request latch.
// Ports:
//   - clk, reset_n: clock and async active-low reset
//   - tick: step enable; debounce only advances on tick cycles
//   - raw: asynchronous sensor input
//   - green: controller green feedback for this road
//   - req: latched service request
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DefDebTicks
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  input  logic green,
  output logic req
);

  localparam int unsigned     CntW   = cnt_width(DEB_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_TICKS);

  logic            sync1_q, sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;

  always_comb begin
    cnt_d = cnt_q;
    req_d = req_q;
    if (tick) begin
      if (!sync_q) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Set wins; it can only coincide with a clear through the one-cycle count lag.
    if (cnt_q == CntMax) begin
      req_d = 1'b1;
    end else if (tick && green && !sync_q) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Front end for the traffic light controller.
// Functions:
//   - tick prescaler
//   - two debounced road request latches
//   - emergency preemption stretcher (IDLE/PREEMPT/HOLD) that keeps all-red
//     for EMG_HOLD ticks after the emergency request drops
// Ports:
//   - clk, reset_n: clock and async active-low reset
//   - bus: slave side of traffic_phase_scheduler_if
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DefTickDiv,
  parameter int unsigned DEB_TICKS = DefDebTicks,
  parameter int unsigned EMG_HOLD  = DefEmgHold
) (
  input logic                       clk,
  input logic                       reset_n,
  traffic_phase_scheduler_if.slave  bus
);

  localparam int unsigned      PreW     = cnt_width(TICK_DIV - 1);
  localparam logic [PreW-1:0]  PreMax   = PreW'(TICK_DIV - 1);
  localparam int unsigned      HoldW    = cnt_width(EMG_HOLD);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(EMG_HOLD);

  // Prescaler
  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;

  always_comb begin
    pre_d  = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
    tick_d = (pre_q == PreMax);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  // Road requests
  sensor_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_deb_a (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick_q),
    .raw    (bus.sa_raw),
    .green  (bus.ga),
    .req    (bus.Sa)
  );

  sensor_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_deb_b (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick_q),
    .raw    (bus.sb_raw),
    .green  (bus.gb),
    .req    (bus.Sb)
  );

  // Emergency path: synchronizer only, no debounce
  logic emg_sync1_q, emg_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emg_sync1_q <= 1'b0;
      emg_s_q     <= 1'b0;
    end else begin
      emg_sync1_q <= bus.emg_raw;
      emg_s_q     <= emg_sync1_q;
    end
  end

  emg_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             emergency_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (emg_s_q) state_d = StPreempt;
      end
      StPreempt: begin
        if (!emg_s_q) begin
          state_d = StHold;
          hold_d  = HoldInit;
        end
      end
      StHold: begin
        // A fresh request abandons the countdown; it reloads on the next exit.
        if (emg_s_q) begin
          state_d = StPreempt;
        end else if (tick_q && (hold_q != '0)) begin
          hold_d = hold_q - HoldW'(1);
          if (hold_q == HoldW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      emergency_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      emergency_q <= (state_d != StIdle);
    end
  end

  assign bus.tick      = tick_q;
  assign bus.emergency = emergency_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler.
// Structure:
//   - directed scenarios followed by random stimulus
//   - every cycle is compared against a behavioural model of the scheduling
//     rules
module tb_traffic_phase_scheduler;

  localparam int unsigned TickDiv  = 4;
  localparam int unsigned DebTicks = 3;
  localparam int unsigned EmgHold  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .TICK_DIV (TickDiv),
    .DEB_TICKS(DebTicks),
    .EMG_HOLD (EmgHold)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  int cyc;          // clock edges since reset release
  bit qa[$], qb[$], qe[$];  // raw samples still inside the 2-cycle sync delay
  int run_a, run_b; // consecutive high tick samples, capped at DebTicks
  bit req_a, req_b;
  bit emg_on;
  int hold_left;    // ticks of hold remaining; -1 while still requested

  task automatic model_reset();
    cyc = 0;
    qa = '{1'b0, 1'b0};
    qb = '{1'b0, 1'b0};
    qe = '{1'b0, 1'b0};
    run_a = 0; run_b = 0;
    req_a = 1'b0; req_b = 1'b0;
    emg_on = 1'b0;
    hold_left = -1;
  endtask

  task automatic deb_step(input bit s, input bit g, input bit tk, input int run_i,
                          input bit req_i, output int run_o, output bit req_o);
    req_o = req_i;
    if (run_i == int'(DebTicks)) req_o = 1'b1;
    else if (tk && g && !s) req_o = 1'b0;
    run_o = run_i;
    if (tk) run_o = s ? ((run_i < int'(DebTicks)) ? run_i + 1 : run_i) : 0;
  endtask

  task automatic model_edge();
    bit tk, sa, sb, se;
    tk = (cyc > 0) && (cyc % TickDiv == 0);
    sa = qa.pop_front(); qa.push_back(bus.sa_raw);
    sb = qb.pop_front(); qb.push_back(bus.sb_raw);
    se = qe.pop_front(); qe.push_back(bus.emg_raw);
    deb_step(sa, bus.ga, tk, run_a, req_a, run_a, req_a);
    deb_step(sb, bus.gb, tk, run_b, req_b, run_b, req_b);
    if (se) begin
      emg_on = 1'b1;
      hold_left = -1;
    end else if (emg_on) begin
      if (hold_left < 0) begin
        hold_left = EmgHold;
      end else if (tk) begin
        hold_left--;
        if (hold_left == 0) emg_on = 1'b0;
      end
    end
    cyc++;
  endtask

  bit rnd = 1'b0;

  // Runs n clocks, comparing all outputs after each edge; returns at a negedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("tick", bus.tick, (cyc > 0) && (cyc % TickDiv == 0));
      check_eq("Sa", bus.Sa, req_a);
      check_eq("Sb", bus.Sb, req_b);
      check_eq("emergency", bus.emergency, emg_on);
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(19) == 0) bus.sa_raw = ~bus.sa_raw;
        if ($urandom_range(19) == 0) bus.sb_raw = ~bus.sb_raw;
        if ($urandom_range(39) == 0) bus.emg_raw = ~bus.emg_raw;
        if ($urandom_range(7) == 0) bus.ga = ~bus.ga;
        if ($urandom_range(7) == 0) bus.gb = ~bus.gb;
      end
    end
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_tick", bus.tick, 1'b0);
    check_eq("rst_async_Sa", bus.Sa, 1'b0);
    check_eq("rst_async_Sb", bus.Sb, 1'b0);
    check_eq("rst_async_emergency", bus.emergency, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sa_raw = 1'b0; bus.sb_raw = 1'b0; bus.emg_raw = 1'b0;
    bus.ga = 1'b0; bus.gb = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tick", bus.tick, 1'b0);
    check_eq("rst_Sa", bus.Sa, 1'b0);
    check_eq("rst_Sb", bus.Sb, 1'b0);
    check_eq("rst_emergency", bus.emergency, 1'b0);
    reset_n = 1'b1;
    model_reset();

    // Idle: ticks only
    run(14);

    // Road A request then service
    bus.sa_raw = 1'b1;
    run(20);
    check_eq("sa_latched", bus.Sa, 1'b1);
    bus.ga = 1'b1; bus.sa_raw = 1'b0;
    run(12);
    check_eq("sa_retired", bus.Sa, 1'b0);
    bus.ga = 1'b0;

    // Road B: two ticks high, one low, two high never reaches DebTicks
    bus.sb_raw = 1'b1; run(8);
    bus.sb_raw = 1'b0; run(4);
    bus.sb_raw = 1'b1; run(8);
    bus.sb_raw = 1'b0; run(4);
    check_eq("sb_not_latched", bus.Sb, 1'b0);

    // One-cycle emergency pulse
    bus.emg_raw = 1'b1; run(1);
    bus.emg_raw = 1'b0; run(1);
    check_eq("emg_not_yet", bus.emergency, 1'b0);
    run(1);
    check_eq("emg_after_3", bus.emergency, 1'b1);
    run(14);

    // Re-assert during hold
    bus.emg_raw = 1'b1; run(6);
    bus.emg_raw = 1'b0; run(3);
    bus.emg_raw = 1'b1; run(4);
    bus.emg_raw = 1'b0; run(16);

    // Reset while Sa is latched and emergency is holding
    bus.sa_raw = 1'b1; run(20);
    bus.emg_raw = 1'b1; run(4);
    bus.emg_raw = 1'b0; run(4);
    check_eq("pre_rst_Sa", bus.Sa, 1'b1);
    check_eq("pre_rst_emergency", bus.emergency, 1'b1);
    bus.sa_raw = 1'b0;
    async_reset();
    run(12);

    // Random traffic with one mid-run reset
    rnd = 1'b1;
    run(3000);
    async_reset();
    run(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
